ysyx_25040111_lsu_wb: RTL and testbench
=======================================

# ysyx_25040111_lsu_wb

Back end of the execute-to-arbiter handshake: accepts one completed instruction at a time from the execute unit's `abt_*` channel, performs its data-memory access (if any) over a single-outstanding request/response bus, and commits the result to the GPR and CSR write ports. It returns `abt_finish`/`abt_frd` to release the execute unit's load read-after-write lock, and emits a one-cycle commit strobe with the retired PC.

## Interface
- No parameters; all widths fixed (RV32, 5-bit GPR index, 12-bit CSR index).
- `clock` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `abt_valid` in 1: execute result valid.
- `abt_ready` out 1: block can accept; high only in IDLE.
- `abt_men` in 1: memory access required.
- `abt_write` in 1: 1 = store, 0 = load (meaningful only when `abt_men`).
- `abt_addr` in 32: byte address.
- `abt_wdata` in 32: store data, LSB-aligned.
- `abt_mask` in 2: size, 01 byte, 10 half, 11 word.
- `abt_rsign` in 1: 1 = sign-extend load, 0 = zero-extend.
- `abt_ard`, `abt_rd`, `abt_gen` in 5/32/1: GPR index, value, write enable.
- `abt_acsr`, `abt_csr`, `abt_sen` in 12/32/1: CSR index, value, write enable.
- `abt_pc` in 32: instruction PC.
- `abt_finish` out 1: one-cycle pulse on load retirement.
- `abt_frd` out 5: GPR index of retiring load.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_req_write` out 1, `mem_req_addr` out 32 (word-aligned, addr[1:0]=0), `mem_req_wdata` out 32 (lane-shifted), `mem_req_wstrb` out 4.
- `mem_rsp_valid` in 1, `mem_rsp_rdata` in 32: response (both loads and stores receive one).
- `gpr_wen` out 1, `gpr_waddr` out 5, `gpr_wdata` out 32.
- `csr_wen` out 1, `csr_waddr` out 12, `csr_wdata` out 32.
- `commit_valid` out 1, `commit_pc` out 32.

## Operation
- States: IDLE, REQ, RSP, WB. Reset -> IDLE.
- IDLE: `abt_ready`=1. On `abt_valid`: latch all `abt_*` inputs; go REQ if `abt_men`, else WB.
- REQ: `mem_req_valid`=1, payload stable until `mem_req_ready`; then RSP.
- RSP: wait `mem_rsp_valid`; latch `mem_rsp_rdata`; go WB.
- WB (exactly one cycle): assert writes/strobes below; go IDLE.
- Byte offset o = addr[1:0]. Strobe base: byte 0001, half 0011, word 1111; `mem_req_wstrb` = (base << o) truncated to 4 bits; `mem_req_wdata` = wdata << 8*o. Loads drive wstrb=0.
- Load data: r = rdata >> 8*o; take low 8/16/32 bits per mask; extend per `rsign`.
- No alignment checking; misaligned lanes beyond byte 3 are dropped.
- WB: `gpr_wen` = gen & (ard != 0); `gpr_wdata` = load data if load, else latched `abt_rd`. `csr_wen` = sen, `csr_wdata` = latched `abt_csr`. `commit_valid`=1, `commit_pc` = latched pc.
- `abt_finish`=1, `abt_frd`=ard in WB only for loads (men & ~write), including ard=0; never for non-loads (would clear a lock owned by a younger load).
- Reset values: all outputs 0 except `abt_ready` (1, IDLE).

## Timing
- Accept at cycle T. Non-memory: WB at T+1, ready again at T+2.
- Memory: REQ from T+1; request fires at R ≥ T+1; RSP from R+1; response at S ≥ R+1; WB at S+1; ready at S+2.
- `mem_rsp_valid` outside RSP is ignored.
- Reset in any state: next cycle IDLE, all strobes low, outstanding request abandoned (no commit, no finish).
- Outputs other than write/commit/finish strobes hold latched values between commits.

## Test plan
- ALU op: gen=1, ard=5, rd=0x1234 -> WB at T+1: gpr_wen, waddr 5, wdata 0x1234, commit_pc = pc; no finish; ready at T+2.
- Signed byte load addr 0x80000003, rdata 0x80FF_0000 -> wstrb 0, req addr 0x80000000, gpr_wdata 0xFFFFFF80, finish=1, frd=ard.
- Unsigned half load addr offset 2, rdata 0xBEEF_0000 -> 0x0000BEEF; signed -> 0xFFFFBEEF.
- Store half 0x0000ABCD at offset 2 -> wstrb 1100, wdata 0xABCD0000; no gpr_wen, no finish; commit once after rsp.
- CSR op: sen=1, gen=1, ard=3, rd=old 0x11, csr=0x22, acsr=0x300 -> gpr x3=0x11 and csr 0x300=0x22 same WB cycle; ard=0 variant -> no gpr_wen.
- mem_req_ready held low 5 cycles, then reset asserted in RSP -> IDLE next cycle, no commit, no finish; stray rsp later ignored.

Source files
------------

// File: rtl/ysyx_25040111_lsu_wb_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25040111_lsu_wb_if
//  Purpose  : Bundles every signal of the load/store + write-back stage:
//             the execute-side abt_* channel, the single-outstanding data
//             memory request/response bus, the GPR and CSR write ports, the
//             load-lock release (finish/frd) and the commit strobe.
//  Modports : slave  - the LSU/WB stage itself
//             master - the surrounding environment (execute unit, memory,
//                      register files, commit observer)
//  Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25040111_lsu_wb_if;

  // Execute -> LSU instruction channel
  logic        abt_valid;
  logic        abt_ready;
  logic        abt_men;
  logic        abt_write;
  logic [31:0] abt_addr;
  logic [31:0] abt_wdata;
  logic [1:0]  abt_mask;
  logic        abt_rsign;
  logic [4:0]  abt_ard;
  logic [31:0] abt_rd;
  logic        abt_gen;
  logic [11:0] abt_acsr;
  logic [31:0] abt_csr;
  logic        abt_sen;
  logic [31:0] abt_pc;

  // Load-lock release back to execute
  logic        abt_finish;
  logic [4:0]  abt_frd;

  // Data memory bus
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  // Register-file write ports
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;

  // Retirement strobe
  logic        commit_valid;
  logic [31:0] commit_pc;

  modport slave (
    input  abt_valid, abt_men, abt_write, abt_addr, abt_wdata, abt_mask,
           abt_rsign, abt_ard, abt_rd, abt_gen, abt_acsr, abt_csr, abt_sen,
           abt_pc, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output abt_ready, abt_finish, abt_frd,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
           mem_req_wstrb,
           gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
           commit_valid, commit_pc
  );

  modport master (
    output abt_valid, abt_men, abt_write, abt_addr, abt_wdata, abt_mask,
           abt_rsign, abt_ard, abt_rd, abt_gen, abt_acsr, abt_csr, abt_sen,
           abt_pc, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  abt_ready, abt_finish, abt_frd,
           mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
           mem_req_wstrb,
           gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
           commit_valid, commit_pc
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_25040111_lsu_wb.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25040111_lsu_wb
//  Purpose  : Load/store and write-back stage. Accepts one completed
//             instruction at a time, performs its (optional) data-memory
//             access over a single-outstanding request/response bus, then
//             commits GPR/CSR results in a single write-back cycle.
//  Ports    : clock  - single clock, all state on posedge
//             reset  - synchronous, active-high
//             lsu    - slave modport of ysyx_25040111_lsu_wb_if:
//               abt_valid/abt_ready   instruction handshake (ready in IDLE)
//               abt_men/abt_write     memory access / store select
//               abt_addr/abt_wdata    byte address, LSB-aligned store data
//               abt_mask/abt_rsign    size (01 B, 10 H, 11 W), sign-extend
//               abt_ard/rd/gen        GPR index, value, enable
//               abt_acsr/csr/sen      CSR index, value, enable
//               abt_pc                instruction PC
//               abt_finish/abt_frd    load retirement pulse + its GPR index
//               mem_req_*             word-aligned request, lane-shifted data
//               mem_rsp_*             response (loads and stores)
//               gpr_*/csr_*           write ports, valid in WB only
//               commit_valid/pc       one-cycle retirement strobe
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_lsu_wb (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_25040111_lsu_wb_if.slave         lsu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t      r_state;

  // Instruction fields captured at acceptance
  logic        r_men;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_mask;
  logic        r_rsign;
  logic [4:0]  r_ard;
  logic [31:0] r_rd;
  logic        r_gen;
  logic [11:0] r_acsr;
  logic [31:0] r_csr;
  logic        r_sen;
  logic [31:0] r_pc;
  logic [31:0] r_rdata;

  // Registered handshake outputs and write-back strobes
  logic        r_ready;
  logic        r_req_valid;
  logic        r_gpr_wen;
  logic        r_csr_wen;
  logic        r_commit;
  logic        r_finish;
  logic [4:0]  r_frd;

  // --------------------------------------------------------------------------
  // Control FSM. Every strobe that must be high in WB is set on the edge that
  // enters WB and cleared on the edge that leaves it, so all outputs come
  // straight from flops.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_men       <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_mask      <= 2'b00;
      r_rsign     <= 1'b0;
      r_ard       <= 5'd0;
      r_rd        <= 32'h0;
      r_gen       <= 1'b0;
      r_acsr      <= 12'h0;
      r_csr       <= 32'h0;
      r_sen       <= 1'b0;
      r_pc        <= 32'h0;
      r_rdata     <= 32'h0;
      r_ready     <= 1'b1;
      r_req_valid <= 1'b0;
      r_gpr_wen   <= 1'b0;
      r_csr_wen   <= 1'b0;
      r_commit    <= 1'b0;
      r_finish    <= 1'b0;
      r_frd       <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (lsu.abt_valid) begin
            r_men   <= lsu.abt_men;
            r_write <= lsu.abt_write;
            r_addr  <= lsu.abt_addr;
            r_wdata <= lsu.abt_wdata;
            r_mask  <= lsu.abt_mask;
            r_rsign <= lsu.abt_rsign;
            r_ard   <= lsu.abt_ard;
            r_rd    <= lsu.abt_rd;
            r_gen   <= lsu.abt_gen;
            r_acsr  <= lsu.abt_acsr;
            r_csr   <= lsu.abt_csr;
            r_sen   <= lsu.abt_sen;
            r_pc    <= lsu.abt_pc;
            r_ready <= 1'b0;
            if (lsu.abt_men) begin
              r_req_valid <= 1'b1;
              r_state     <= ST_REQ;
            end else begin
              // Non-memory op retires immediately; never a load, so no finish.
              r_gpr_wen <= lsu.abt_gen & (|lsu.abt_ard);
              r_csr_wen <= lsu.abt_sen;
              r_commit  <= 1'b1;
              r_state   <= ST_WB;
            end
          end
        end

        ST_REQ: begin
          if (lsu.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (lsu.mem_rsp_valid) begin
            r_rdata   <= lsu.mem_rsp_rdata;
            r_gpr_wen <= r_gen & (|r_ard);
            r_csr_wen <= r_sen;
            r_commit  <= 1'b1;
            // Only a load owns the execute-side RAW lock; ard=0 still
            // releases it because the lock was taken regardless of index.
            if (!r_write) begin
              r_finish <= 1'b1;
              r_frd    <= r_ard;
            end
            r_state <= ST_WB;
          end
        end

        ST_WB: begin
          r_gpr_wen <= 1'b0;
          r_csr_wen <= 1'b0;
          r_commit  <= 1'b0;
          r_finish  <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Lane alignment
  // --------------------------------------------------------------------------
  logic [4:0]  w_lane_shift;
  logic [3:0]  w_strb_base;
  logic [3:0]  w_wstrb;
  logic [31:0] w_rsh;
  logic [31:0] w_load_data;
  logic        w_is_load;

  assign w_lane_shift = {r_addr[1:0], 3'b000};
  assign w_is_load    = r_men & ~r_write;

  always_comb begin
    w_strb_base = 4'b0000;
    case (r_mask)
      2'b01:   w_strb_base = 4'b0001;
      2'b10:   w_strb_base = 4'b0011;
      2'b11:   w_strb_base = 4'b1111;
      default: w_strb_base = 4'b0000;
    endcase
  end

  // Shifting inside a 4-bit result drops lanes past byte 3 for misaligned
  // accesses, which is the intended behaviour (no alignment trap here).
  assign w_wstrb = (r_men & r_write) ? (w_strb_base << r_addr[1:0]) : 4'b0000;

  assign w_rsh = r_rdata >> w_lane_shift;

  always_comb begin
    w_load_data = w_rsh;
    case (r_mask)
      2'b01:   w_load_data = {{24{r_rsign & w_rsh[7]}},  w_rsh[7:0]};
      2'b10:   w_load_data = {{16{r_rsign & w_rsh[15]}}, w_rsh[15:0]};
      default: w_load_data = w_rsh;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign lsu.abt_ready     = r_ready;
  assign lsu.abt_finish    = r_finish;
  assign lsu.abt_frd       = r_frd;

  assign lsu.mem_req_valid = r_req_valid;
  assign lsu.mem_req_write = r_men & r_write;
  assign lsu.mem_req_addr  = {r_addr[31:2], 2'b00};
  assign lsu.mem_req_wdata = r_wdata << w_lane_shift;
  assign lsu.mem_req_wstrb = w_wstrb;

  assign lsu.gpr_wen       = r_gpr_wen;
  assign lsu.gpr_waddr     = r_ard;
  assign lsu.gpr_wdata     = w_is_load ? w_load_data : r_rd;

  assign lsu.csr_wen       = r_csr_wen;
  assign lsu.csr_waddr     = r_acsr;
  assign lsu.csr_wdata     = r_csr;

  assign lsu.commit_valid  = r_commit;
  assign lsu.commit_pc     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_lsu_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25040111_lsu_wb
//  Purpose  : Self-checking bench for ysyx_25040111_lsu_wb. Expected commits
//             are queued when an instruction is issued and compared when the
//             DUT raises commit_valid; per-scenario tasks check handshake
//             timing and memory request payloads inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_lsu_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ysyx_25040111_lsu_wb_if lsu_if ();

  ysyx_25040111_lsu_wb dut (
    .clock (clk),
    .reset (rst),
    .lsu   (lsu_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        gwen;
    logic [4:0]  gaddr;
    logic [31:0] gdata;
    logic        cwen;
    logic [11:0] caddr;
    logic [31:0] cdata;
    logic [31:0] pc;
    logic        fin;
    logic [4:0]  frd;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  function automatic exp_t mk_exp(input logic gwen, input logic [4:0] gaddr,
                                  input logic [31:0] gdata, input logic cwen,
                                  input logic [11:0] caddr, input logic [31:0] cdata,
                                  input logic [31:0] pc, input logic fin,
                                  input logic [4:0] frd);
    exp_t e;
    e.gwen = gwen; e.gaddr = gaddr; e.gdata = gdata;
    e.cwen = cwen; e.caddr = caddr; e.cdata = cdata;
    e.pc = pc; e.fin = fin; e.frd = frd;
    return e;
  endfunction

  // Scoreboard: every commit must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (lsu_if.commit_valid) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_commit: got commit pc=%h, required none", lsu_if.commit_pc);
        end else begin
          mon_e = sbq.pop_front();
          if (lsu_if.commit_pc !== mon_e.pc) begin
            bad++; $display("FAIL commit_pc: got %h need %h", lsu_if.commit_pc, mon_e.pc);
          end
          total++;
          if (lsu_if.gpr_wen !== mon_e.gwen) begin
            bad++; $display("FAIL gpr_wen: got %b need %b (pc %h)", lsu_if.gpr_wen, mon_e.gwen, mon_e.pc);
          end
          total++;
          if (lsu_if.gpr_waddr !== mon_e.gaddr) begin
            bad++; $display("FAIL gpr_waddr: got %0d need %0d (pc %h)", lsu_if.gpr_waddr, mon_e.gaddr, mon_e.pc);
          end
          total++;
          if (lsu_if.gpr_wdata !== mon_e.gdata) begin
            bad++; $display("FAIL gpr_wdata: got %h need %h (pc %h)", lsu_if.gpr_wdata, mon_e.gdata, mon_e.pc);
          end
          total++;
          if (lsu_if.csr_wen !== mon_e.cwen) begin
            bad++; $display("FAIL csr_wen: got %b need %b (pc %h)", lsu_if.csr_wen, mon_e.cwen, mon_e.pc);
          end
          total++;
          if (lsu_if.csr_waddr !== mon_e.caddr || lsu_if.csr_wdata !== mon_e.cdata) begin
            bad++; $display("FAIL csr_write: got %h/%h need %h/%h (pc %h)", lsu_if.csr_waddr,
                            lsu_if.csr_wdata, mon_e.caddr, mon_e.cdata, mon_e.pc);
          end
          total++;
          if (lsu_if.abt_finish !== mon_e.fin) begin
            bad++; $display("FAIL abt_finish: got %b need %b (pc %h)", lsu_if.abt_finish, mon_e.fin, mon_e.pc);
          end
          if (mon_e.fin) begin
            total++;
            if (lsu_if.abt_frd !== mon_e.frd) begin
              bad++; $display("FAIL abt_frd: got %0d need %0d (pc %h)", lsu_if.abt_frd, mon_e.frd, mon_e.pc);
            end
          end
        end
      end else if (lsu_if.abt_finish || lsu_if.gpr_wen || lsu_if.csr_wen) begin
        total++;
        bad++;
        $display("FAIL stray_strobe: got finish=%b gpr_wen=%b csr_wen=%b without commit, required 0",
                 lsu_if.abt_finish, lsu_if.gpr_wen, lsu_if.csr_wen);
      end
    end
  end

  // Drive one instruction; entered and left on a negedge. Returns on the
  // negedge after the accepting posedge.
  task automatic issue(input logic men, input logic write, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] mask, input logic rsign,
                       input logic [4:0] ard, input logic [31:0] rd, input logic gen,
                       input logic [11:0] acsr, input logic [31:0] csr, input logic sen,
                       input logic [31:0] pc);
    int n;
    n = 0;
    while (lsu_if.abt_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (lsu_if.abt_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: got abt_ready=%b after %0d cycles, required 1", lsu_if.abt_ready, n);
    end
    lsu_if.abt_men   = men;
    lsu_if.abt_write = write;
    lsu_if.abt_addr  = addr;
    lsu_if.abt_wdata = wdata;
    lsu_if.abt_mask  = mask;
    lsu_if.abt_rsign = rsign;
    lsu_if.abt_ard   = ard;
    lsu_if.abt_rd    = rd;
    lsu_if.abt_gen   = gen;
    lsu_if.abt_acsr  = acsr;
    lsu_if.abt_csr   = csr;
    lsu_if.abt_sen   = sen;
    lsu_if.abt_pc    = pc;
    lsu_if.abt_valid = 1'b1;
    @(negedge clk);
    lsu_if.abt_valid = 1'b0;
    lsu_if.abt_men   = 1'b0;
    lsu_if.abt_gen   = 1'b0;
    lsu_if.abt_sen   = 1'b0;
  endtask

  // Memory model for one transaction: captures the request payload, stalls
  // ready for 'delay' cycles, then responds one cycle after the handshake.
  // Returns on the negedge of the WB cycle.
  task automatic mem_serve(input int delay, input logic [31:0] rdata,
                           output logic [31:0] q_addr, output logic [31:0] q_wdata,
                           output logic [3:0] q_wstrb, output logic q_write,
                           output logic timed_out);
    int n;
    n = 0;
    while (lsu_if.mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    timed_out = (lsu_if.mem_req_valid !== 1'b1);
    q_addr    = lsu_if.mem_req_addr;
    q_wdata   = lsu_if.mem_req_wdata;
    q_wstrb   = lsu_if.mem_req_wstrb;
    q_write   = lsu_if.mem_req_write;
    if (!timed_out) begin
      repeat (delay) @(negedge clk);
      lsu_if.mem_req_ready = 1'b1;
      @(negedge clk);
      lsu_if.mem_req_ready = 1'b0;
      lsu_if.mem_rsp_valid = 1'b1;
      lsu_if.mem_rsp_rdata = rdata;
      @(negedge clk);
      lsu_if.mem_rsp_valid = 1'b0;
      lsu_if.mem_rsp_rdata = 32'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (lsu_if.abt_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b need 1", lsu_if.abt_ready);
    end
    total++;
    if ({lsu_if.mem_req_valid, lsu_if.gpr_wen, lsu_if.csr_wen, lsu_if.commit_valid,
         lsu_if.abt_finish, lsu_if.mem_req_write} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got req=%b gwen=%b cwen=%b commit=%b fin=%b wr=%b need all 0",
                      lsu_if.mem_req_valid, lsu_if.gpr_wen, lsu_if.csr_wen, lsu_if.commit_valid,
                      lsu_if.abt_finish, lsu_if.mem_req_write);
    end
    total++;
    if (lsu_if.mem_req_addr !== 32'h0 || lsu_if.mem_req_wstrb !== 4'h0 ||
        lsu_if.commit_pc !== 32'h0 || lsu_if.gpr_wdata !== 32'h0 || lsu_if.abt_frd !== 5'd0) begin
      bad++; $display("FAIL reset_values: got addr=%h strb=%h pc=%h gdata=%h frd=%0d need all 0",
                      lsu_if.mem_req_addr, lsu_if.mem_req_wstrb, lsu_if.commit_pc,
                      lsu_if.gpr_wdata, lsu_if.abt_frd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    sbq.push_back(mk_exp(1'b1, 5'd5, 32'h0000_1234, 1'b0, 12'h0, 32'h0, 32'h8000_0100, 1'b0, 5'd0));
    issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd5, 32'h0000_1234, 1'b1, 12'h0, 32'h0, 1'b0,
          32'h8000_0100);
    total++;
    if (lsu_if.commit_valid !== 1'b1 || lsu_if.abt_ready !== 1'b0) begin
      bad++; $display("FAIL alu_wb_timing: got commit=%b ready=%b at T+1 need 1/0",
                      lsu_if.commit_valid, lsu_if.abt_ready);
    end
    @(negedge clk);
    total++;
    if (lsu_if.commit_valid !== 1'b0 || lsu_if.abt_ready !== 1'b1) begin
      bad++; $display("FAIL alu_ready_timing: got commit=%b ready=%b at T+2 need 0/1",
                      lsu_if.commit_valid, lsu_if.abt_ready);
    end
  endtask

  task automatic test_loads();
    logic [31:0] qa, qd;
    logic [3:0]  qs;
    logic        qw, to;
    // Signed byte at offset 3
    sbq.push_back(mk_exp(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 12'h0, 32'h0, 32'h8000_0104, 1'b1, 5'd7));
    issue(1'b1, 1'b0, 32'h8000_0003, 32'hFFFF_FFFF, 2'b01, 1'b1, 5'd7, 32'h0000_AAAA, 1'b1,
          12'h0, 32'h0, 1'b0, 32'h8000_0104);
    mem_serve(1, 32'h80FF_0000, qa, qd, qs, qw, to);
    total++;
    if (to || qa !== 32'h8000_0000 || qs !== 4'b0000 || qw !== 1'b0) begin
      bad++; $display("FAIL lb_req: got to=%b addr=%h strb=%b wr=%b need 0/80000000/0000/0", to, qa, qs, qw);
    end
    @(negedge clk);
    // Half at offset 2, unsigned then signed
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(mk_exp(1'b1, 5'd9, (i == 1) ? 32'hFFFF_BEEF : 32'h0000_BEEF, 1'b0, 12'h0, 32'h0,
                           32'h8000_0200 + 32'(i * 4), 1'b1, 5'd9));
      issue(1'b1, 1'b0, 32'h0000_1002, 32'h0, 2'b10, 1'(i), 5'd9, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0,
            32'h8000_0200 + 32'(i * 4));
      mem_serve(0, 32'hBEEF_0000, qa, qd, qs, qw, to);
      total++;
      if (to || qa !== 32'h0000_1000 || qs !== 4'b0000) begin
        bad++; $display("FAIL lh_req_%0d: got to=%b addr=%h strb=%b need 0/00001000/0000", i, to, qa, qs);
      end
      @(negedge clk);
    end
    // Word load into x0: no GPR write but the lock is still released
    sbq.push_back(mk_exp(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0, 32'h8000_0300, 1'b1, 5'd0));
    issue(1'b1, 1'b0, 32'h0000_2000, 32'h0, 2'b11, 1'b0, 5'd0, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0,
          32'h8000_0300);
    mem_serve(3, 32'hDEAD_BEEF, qa, qd, qs, qw, to);
    total++;
    if (to || qa !== 32'h0000_2000) begin
      bad++; $display("FAIL lw_req: got to=%b addr=%h need 0/00002000", to, qa);
    end
    @(negedge clk);
  endtask

  task automatic test_stores();
    logic [31:0] qa, qd;
    logic [3:0]  qs;
    logic        qw, to;
    logic [31:0] st_addr  [3] = '{32'h0000_3002, 32'h0000_3005, 32'h0000_3003};
    logic [31:0] st_data  [3] = '{32'h0000_ABCD, 32'h1122_3344, 32'h0000_0078};
    logic [1:0]  st_mask  [3] = '{2'b10, 2'b11, 2'b01};
    logic [31:0] ex_addr  [3] = '{32'h0000_3000, 32'h0000_3004, 32'h0000_3000};
    logic [31:0] ex_data  [3] = '{32'hABCD_0000, 32'h2233_4400, 32'h7800_0000};
    logic [3:0]  ex_strb  [3] = '{4'b1100, 4'b1110, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(mk_exp(1'b0, 5'd4, 32'h0000_0055, 1'b0, 12'h0, 32'h0, 32'h8000_0400 + 32'(i * 4),
                           1'b0, 5'd0));
      issue(1'b1, 1'b1, st_addr[i], st_data[i], st_mask[i], 1'b0, 5'd4, 32'h0000_0055, 1'b0,
            12'h0, 32'h0, 1'b0, 32'h8000_0400 + 32'(i * 4));
      mem_serve(2, 32'hFFFF_FFFF, qa, qd, qs, qw, to);
      total++;
      if (to || qw !== 1'b1 || qa !== ex_addr[i] || qs !== ex_strb[i] || qd !== ex_data[i]) begin
        bad++; $display("FAIL store_req_%0d: got to=%b wr=%b addr=%h strb=%b data=%h need 0/1/%h/%b/%h",
                        i, to, qw, qa, qs, qd, ex_addr[i], ex_strb[i], ex_data[i]);
      end
      @(negedge clk);
      total++;
      if (lsu_if.commit_valid !== 1'b0) begin
        bad++; $display("FAIL store_commit_once_%0d: got commit=%b need 0", i, lsu_if.commit_valid);
      end
    end
  endtask

  task automatic test_csr();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] ard;
      ard = (i == 0) ? 5'd3 : 5'd0;
      sbq.push_back(mk_exp(i == 0, ard, 32'h11, 1'b1, 12'h300, 32'h22, 32'h8000_0500 + 32'(i * 4),
                           1'b0, 5'd0));
      issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, ard, 32'h11, 1'b1, 12'h300, 32'h22, 1'b1,
            32'h8000_0500 + 32'(i * 4));
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    sbq.push_back(mk_exp(1'b1, 5'd10, 32'hA5A5_0001, 1'b0, 12'h0, 32'h0, 32'h8000_0600, 1'b0, 5'd0));
    sbq.push_back(mk_exp(1'b1, 5'd11, 32'hA5A5_0002, 1'b0, 12'h0, 32'h0, 32'h8000_0604, 1'b0, 5'd0));
    issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd10, 32'hA5A5_0001, 1'b1, 12'h0, 32'h0, 1'b0,
          32'h8000_0600);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd11, 32'hA5A5_0002, 1'b1, 12'h0, 32'h0, 1'b0,
          32'h8000_0604);
    total++;
    if (lsu_if.commit_valid !== 1'b1 || lsu_if.commit_pc !== 32'h8000_0604) begin
      bad++; $display("FAIL b2b_second_wb: got commit=%b pc=%h need 1/80000604",
                      lsu_if.commit_valid, lsu_if.commit_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    issue(1'b1, 1'b0, 32'h0000_4000, 32'h0, 2'b11, 1'b0, 5'd6, 32'h0, 1'b1, 12'h0, 32'h0, 1'b0,
          32'h8000_0700);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (lsu_if.mem_req_valid !== 1'b1 || lsu_if.mem_req_addr !== 32'h0000_4000) begin
        bad++; $display("FAIL stall_hold_%0d: got valid=%b addr=%h need 1/00004000",
                        i, lsu_if.mem_req_valid, lsu_if.mem_req_addr);
      end
      @(negedge clk);
    end
    lsu_if.mem_req_ready = 1'b1;
    @(negedge clk);
    lsu_if.mem_req_ready = 1'b0;
    total++;
    if (lsu_if.mem_req_valid !== 1'b0 || lsu_if.abt_ready !== 1'b0) begin
      bad++; $display("FAIL rsp_wait: got valid=%b ready=%b need 0/0", lsu_if.mem_req_valid, lsu_if.abt_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (lsu_if.abt_ready !== 1'b1 || lsu_if.commit_valid !== 1'b0 || lsu_if.abt_finish !== 1'b0 ||
        lsu_if.mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL abort_reset: got ready=%b commit=%b fin=%b req=%b need 1/0/0/0",
                      lsu_if.abt_ready, lsu_if.commit_valid, lsu_if.abt_finish, lsu_if.mem_req_valid);
    end
    rst = 1'b0;
    lsu_if.mem_rsp_valid = 1'b1;
    lsu_if.mem_rsp_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (lsu_if.abt_ready !== 1'b1 || lsu_if.commit_valid !== 1'b0) begin
        bad++; $display("FAIL stray_rsp_%0d: got ready=%b commit=%b need 1/0",
                        i, lsu_if.abt_ready, lsu_if.commit_valid);
      end
    end
    lsu_if.mem_rsp_valid = 1'b0;
    lsu_if.mem_rsp_rdata = 32'h0;
    // Stage still usable after the abandoned access
    sbq.push_back(mk_exp(1'b1, 5'd12, 32'h0BAD_0001, 1'b0, 12'h0, 32'h0, 32'h8000_0800, 1'b0, 5'd0));
    issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd12, 32'h0BAD_0001, 1'b1, 12'h0, 32'h0, 1'b0,
          32'h8000_0800);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lsu_if.abt_valid     = 1'b0;
    lsu_if.abt_men       = 1'b0;
    lsu_if.abt_write     = 1'b0;
    lsu_if.abt_addr      = 32'h0;
    lsu_if.abt_wdata     = 32'h0;
    lsu_if.abt_mask      = 2'b00;
    lsu_if.abt_rsign     = 1'b0;
    lsu_if.abt_ard       = 5'd0;
    lsu_if.abt_rd        = 32'h0;
    lsu_if.abt_gen       = 1'b0;
    lsu_if.abt_acsr      = 12'h0;
    lsu_if.abt_csr       = 32'h0;
    lsu_if.abt_sen       = 1'b0;
    lsu_if.abt_pc        = 32'h0;
    lsu_if.mem_req_ready = 1'b0;
    lsu_if.mem_rsp_valid = 1'b0;
    lsu_if.mem_rsp_rdata = 32'h0;

    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_csr();
    test_back_to_back();
    test_abort();

    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d commits outstanding, need 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
